seg_scan: RTL and testbench

- Display back-end that sits directly downstream of the cpu core and drives the board's 8-digit common-anode seven-segment display through SEG/AN.
- Takes a 32-bit value (8 hex nibbles) plus a decimal-point mask.
- Double-buffers the value so digits never tear mid-frame.
- Time-multiplexes the anodes with inter-digit blanking to suppress ghosting.

---
 rtl/seg_scan.sv | 168 ++++++++++++++++
 tb/tb_seg_scan.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: 8-digit multiplexed seven-segment driver.
// Double-buffered frame, per-slot anode blanking.
module seg_scan #(
  parameter int SCAN_DIV = 100000,
  parameter int BLANK    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [7:0]  dp_mask,
  input  logic        blank_lz,
  input  logic        load,
  output logic        load_ack,
  output logic        frame_done,
  output logic [7:0]  SEG,
  output logic [7:0]  AN
);

  localparam int CW =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLK = CW'(BLANK);

  typedef struct packed {
    logic [31:0] val;
    logic [7:0]  dp;
    logic        blz;
  } frame_t;

  typedef enum logic {
    ST_WAIT,
    ST_SCAN
  } st_e;

  logic [CW-1:0] div_q, div_d;
  logic [2:0]    idx_q, idx_d;
  st_e           st_q, st_d;
  frame_t        shadow_q, shadow_d;
  frame_t        pend_q, pend_d;
  logic          pv_q, pv_d;
  logic          ack_q, ack_d;
  logic          fd_q, fd_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          tick;
  logic          boundary;
  frame_t        in_frame;

  logic [31:0]   upper;
  logic [3:0]    nib;
  logic          lz;
  logic [6:0]    seg7;

  function automatic logic [6:0] hex7(
    input logic [3:0] n
  );
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // slot divider, digit index and scan-start state
  always_comb begin
    tick     = (div_q == LAST);
    boundary = tick && (idx_q == 3'd7);
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    fd_d     = boundary;
    st_d     = st_q;
    unique case (st_q)
      ST_WAIT: if (tick) st_d = ST_SCAN;
      ST_SCAN: st_d = ST_SCAN;
      default: st_d = ST_WAIT;
    endcase
  end

  // pending/shadow double buffer; swap only on frame wrap
  always_comb begin
    in_frame = '{val: data, dp: dp_mask,
                 blz: blank_lz};
    shadow_d = shadow_q;
    pend_d   = pend_q;
    pv_d     = pv_q;
    ack_d    = 1'b0;
    if (boundary) begin
      if (load) begin
        shadow_d = in_frame;
        pv_d     = 1'b0;
        ack_d    = 1'b1;
      end else if (pv_q) begin
        shadow_d = pend_q;
        pv_d     = 1'b0;
        ack_d    = 1'b1;
      end
    end else if (load) begin
      pend_d = in_frame;
      pv_d   = 1'b1;
    end
  end

  // next anode/cathode pattern from next-cycle slot state
  always_comb begin
    upper = shadow_d.val >> {idx_d, 2'b00};
    nib   = upper[3:0];
    lz    = shadow_d.blz && (idx_d != 3'd0)
            && (upper == 32'd0);
    seg7  = lz ? 7'h7F : hex7(nib);
    an_d  = 8'hFF;
    seg_d = 8'hFF;
    if ((st_d == ST_SCAN) && (div_d >= BLK)) begin
      an_d  = ~(8'b1 << idx_d);
      seg_d = {~shadow_d.dp[idx_d], seg7};
    end
  end

  // state registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      idx_q    <= 3'd7;
      st_q     <= ST_WAIT;
      shadow_q <= '0;
      pend_q   <= '0;
      pv_q     <= 1'b0;
      ack_q    <= 1'b0;
      fd_q     <= 1'b0;
      an_q     <= 8'hFF;
      seg_q    <= 8'hFF;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      st_q     <= st_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      pv_q     <= pv_d;
      ack_q    <= ack_d;
      fd_q     <= fd_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign load_ack   = ack_q;
  assign frame_done = fd_q;
  assign AN         = an_q;
  assign SEG        = seg_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: randomized scoreboard bench for seg_scan.
// Timing-level reference model, per-cycle output compare.
module tb_seg_scan;

  localparam int SD = 8;
  localparam int BL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [7:0]  dp_mask;
  logic        blank_lz;
  logic        load;
  logic        load_ack;
  logic        frame_done;
  logic [7:0]  SEG;
  logic [7:0]  AN;

  seg_scan #(
    .SCAN_DIV(SD),
    .BLANK(BL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data(data),
    .dp_mask(dp_mask),
    .blank_lz(blank_lz),
    .load(load),
    .load_ack(load_ack),
    .frame_done(frame_done),
    .SEG(SEG),
    .AN(AN)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tab [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0,
    8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83,
    8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  int n_chk  = 0;
  int n_fail = 0;
  int t      = 0;

  logic [31:0] m_val, p_val;
  logic [7:0]  m_dp, p_dp;
  logic        m_bz, p_bz, p_v, m_ack;

  logic [17:0] exp_q [$];
  int          cyc_q [$];

  function automatic bit is_bnd(int c);
    return ((c + 1) >= SD) &&
           (((c + 1 - SD) % (8 * SD)) == 0);
  endfunction

  function automatic int dig(int c);
    return ((c - SD) / SD) % 8;
  endfunction

  function automatic int kof(int c);
    return c % SD;
  endfunction

  function automatic logic [17:0] model_out(int c);
    logic [7:0]  an, sg;
    logic        fd;
    logic [31:0] up;
    int          d;
    an = 8'hFF;
    sg = 8'hFF;
    fd = 1'b0;
    if (c >= SD) begin
      d  = dig(c);
      fd = (((c - SD) % (8 * SD)) == 0);
      if (kof(c) >= BL) begin
        an = ~(8'h01 << d);
        up = m_val >> (4 * d);
        sg = seg_tab[up[3:0]];
        if (m_bz && d != 0 && up == 32'd0)
          sg = 8'hFF;
        sg[7] = ~m_dp[d];
      end
    end
    return {m_ack, fd, an, sg};
  endfunction

  task automatic model_reset();
    t     = 0;
    m_val = '0; m_dp = '0; m_bz = 1'b0;
    p_val = '0; p_dp = '0; p_bz = 1'b0;
    p_v   = 1'b0;
    m_ack = 1'b0;
  endtask

  task automatic model_step(
    input logic ld, input logic [31:0] dv,
    input logic [7:0] dpv, input logic bz
  );
    m_ack = 1'b0;
    if (is_bnd(t)) begin
      if (ld) begin
        m_val = dv; m_dp = dpv; m_bz = bz;
        p_v = 1'b0; m_ack = 1'b1;
      end else if (p_v) begin
        m_val = p_val; m_dp = p_dp; m_bz = p_bz;
        p_v = 1'b0; m_ack = 1'b1;
      end
    end else if (ld) begin
      p_val = dv; p_dp = dpv; p_bz = bz;
      p_v = 1'b1;
    end
  endtask

  task automatic check(
    input string nm, input logic [31:0] got,
    input logic [31:0] want
  );
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h",
               nm, got, want);
    end
  endtask

  // one clock cycle of stimulus; called at posedge+1
  task automatic cycle(
    input logic ld, input logic [31:0] dv,
    input logic [7:0] dpv, input logic bz
  );
    load = ld; data = dv;
    dp_mask = dpv; blank_lz = bz;
    exp_q.push_back(model_out(t));
    cyc_q.push_back(t);
    model_step(ld, dv, dpv, bz);
    t++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, $urandom(), 8'($urandom()),
            1'($urandom()));
  endtask

  // monitor: pop and compare once per sampled cycle
  always @(negedge clk) begin
    logic [17:0] e, g;
    int          c;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cyc_q.pop_front();
      g = {load_ack, frame_done, AN, SEG};
      n_chk++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL cyc%0d ack/fd/AN/SEG: got %b %b %h %h want %b %b %h %h",
                 c, g[17], g[16], g[15:8], g[7:0],
                 e[17], e[16], e[15:8], e[7:0]);
      end
    end
  end

  initial begin
    int guard;
    rst = 1'b0; load = 1'b0; data = '0;
    dp_mask = '0; blank_lz = 1'b0;
    model_reset();
    #12;
    check("rst_out", {14'd0, load_ack, frame_done,
          AN, SEG}, {14'd0, 2'b00, 8'hFF, 8'hFF});
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();

    // idle after reset, then mid-frame load
    idle(100);
    cycle(1'b1, 32'h89ABCDEF, 8'h00, 1'b0);
    idle(180);

    // two loads inside one frame, latest wins
    cycle(1'b1, 32'h00000001, 8'h00, 1'b0);
    idle(9);
    cycle(1'b1, 32'h00000002, 8'h00, 1'b0);
    idle(110);

    // load exactly in the boundary cycle
    guard = 0;
    while (!is_bnd(t) && guard < 200) begin
      idle(1);
      guard++;
    end
    check("bnd_found", 32'(is_bnd(t)), 32'd1);
    cycle(1'b1, 32'h00000005, 8'h00, 1'b0);
    idle(80);

    // leading-zero blanking with a dp
    cycle(1'b1, 32'h00000120, 8'h04, 1'b1);
    idle(150);

    // randomized loads, some on boundaries
    for (int i = 0; i < 600; i++) begin
      logic ld;
      ld = ($urandom_range(0, 14) == 0) ||
           (is_bnd(t) && $urandom_range(0, 1) == 1);
      if (ld)
        cycle(1'b1,
              $urandom() >> (4 * $urandom_range(0, 8)),
              8'($urandom()), 1'($urandom()));
      else
        idle(1);
    end

    // pending load, then async reset on digit 2
    guard = 0;
    while (!(t >= SD && dig(t) == 0 &&
             kof(t) == 5) && guard < 200) begin
      idle(1);
      guard++;
    end
    cycle(1'b1, 32'hDEADBEEF, 8'hFF, 1'b0);
    guard = 0;
    while (!(t >= SD && dig(t) == 2 &&
             kof(t) >= BL) && guard < 200) begin
      idle(1);
      guard++;
    end
    check("pre_rst_AN", {24'd0, AN}, 32'h000000FB);
    #1;
    rst = 1'b0;
    #1;
    check("async_rst", {14'd0, load_ack, frame_done,
          AN, SEG}, {14'd0, 2'b00, 8'hFF, 8'hFF});
    repeat (3) @(posedge clk);
    #1;
    check("held_rst", {16'd0, AN, SEG},
          {16'd0, 8'hFF, 8'hFF});
    rst = 1'b1;
    model_reset();
    idle(80);

    @(negedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
